wb_reg_file: RTL and testbench

Write-back-stage register file for the 5-stage pipeline. It sits at the consuming end of the MEM/WB pipeline register: it takes the write-back control and data outputs of MEM/WB, selects the write-back value, and commits it to a 32×32 general register file. It serves two combinational read ports to the ID stage, with optional same-cycle write-to-read bypass, and keeps a retired-instruction counter.

---
 rtl/wb_reg_file_if.sv | 31 +++
 rtl/wb_reg_file.sv | 79 +++++++
 tb/tb_wb_reg_file.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_reg_file_if.sv
// Write-back bus between the MEM/WB pipeline register, the ID-stage read
// ports and the register file. The master drives the write-back controls and
// read addresses; the register file (slave) returns read data, the selected
// write-back value and the retired-instruction count.
interface wb_reg_file_if #(
    parameter int WIDTH = 32
);
    logic             En;
    logic             Wreg;
    logic             M2reg;
    logic [WIDTH-1:0] Mem_data;
    logic [WIDTH-1:0] Alu_data;
    logic [4:0]       Wn;
    logic             Valid;
    logic [4:0]       Rn1;
    logic [4:0]       Rn2;
    logic [WIDTH-1:0] Qa;
    logic [WIDTH-1:0] Qb;
    logic [WIDTH-1:0] Wdata;
    logic [WIDTH-1:0] Retired;

    modport master (
        output En, Wreg, M2reg, Mem_data, Alu_data, Wn, Valid, Rn1, Rn2,
        input  Qa, Qb, Wdata, Retired
    );

    modport slave (
        input  En, Wreg, M2reg, Mem_data, Alu_data, Wn, Valid, Rn1, Rn2,
        output Qa, Qb, Wdata, Retired
    );
endinterface

// File: rtl/wb_reg_file.sv
// Write-back stage register file: selects the write-back value, commits it to
// a 32-entry register file (entry 0 hard-wired to zero), serves two
// combinational read ports with optional same-cycle bypass and counts retired
// instructions. Clrn is an asynchronous, active-high clear.
module wb_reg_file #(
    parameter bit BYPASS = 1'b1,
    parameter int WIDTH  = 32
) (
    input logic          Clk,
    input logic          Clrn,
    wb_reg_file_if.slave bus
);
    // Entry 0 has no storage; reads of address 0 are forced to zero below.
    logic [WIDTH-1:0] regs_q [31:1];
    logic [WIDTH-1:0] retired_q;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;

    // Write-back value is always presented, whatever Wreg/En say.
    always_comb begin
        wdata = bus.M2reg ? bus.Mem_data : bus.Alu_data;
    end

    // A write is pending only when enabled and aimed at a real register.
    always_comb begin
        wr_en = bus.En && bus.Wreg && (bus.Wn != 5'd0);
    end

    // Register storage: async clear, one-edge write latency.
    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.Wn] <= wdata;
        end
    end

    // Retired counter: counts every valid, non-stalled instruction and wraps silently.
    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            retired_q <= '0;
        end else if (bus.En && bus.Valid) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    // Read port A: zero register, then optional bypass of the pending write, then storage.
    always_comb begin
        qa = '0;
        if (bus.Rn1 != 5'd0) begin
            if (BYPASS && wr_en && (bus.Rn1 == bus.Wn)) begin
                qa = wdata;
            end else begin
                qa = regs_q[bus.Rn1];
            end
        end
    end

    // Read port B: same rules as port A, independently of it.
    always_comb begin
        qb = '0;
        if (bus.Rn2 != 5'd0) begin
            if (BYPASS && wr_en && (bus.Rn2 == bus.Wn)) begin
                qb = wdata;
            end else begin
                qb = regs_q[bus.Rn2];
            end
        end
    end

    assign bus.Qa      = qa;
    assign bus.Qb      = qb;
    assign bus.Wdata   = wdata;
    assign bus.Retired = retired_q;
endmodule

// File: tb/tb_wb_reg_file.sv
`timescale 1ns/100ps
// Self-checking bench for wb_reg_file. Two instances run side by side on
// identical stimulus: one with bypass enabled, one without.
module tb_wb_reg_file;
    logic        Clk;
    logic        Clrn;
    int          n_cmp;
    int          n_mis;
    logic [31:0] exp_q[$];
    logic [31:0] ret_exp;

    wb_reg_file_if #(.WIDTH(32)) bus1 ();
    wb_reg_file_if #(.WIDTH(32)) bus0 ();

    assign bus0.En       = bus1.En;
    assign bus0.Wreg     = bus1.Wreg;
    assign bus0.M2reg    = bus1.M2reg;
    assign bus0.Mem_data = bus1.Mem_data;
    assign bus0.Alu_data = bus1.Alu_data;
    assign bus0.Wn       = bus1.Wn;
    assign bus0.Valid    = bus1.Valid;
    assign bus0.Rn1      = bus1.Rn1;
    assign bus0.Rn2      = bus1.Rn2;

    wb_reg_file #(.BYPASS(1'b1), .WIDTH(32)) u_byp (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus1)
    );

    wb_reg_file #(.BYPASS(1'b0), .WIDTH(32)) u_nobyp (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus0)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Upstream should never send a write from a bubble; flag it, do not fail.
    always @(posedge Clk) begin
        if (!Clrn && bus1.En && bus1.Wreg && !bus1.Valid)
            $warning("write-back from a bubble (Valid=0, Wreg=1)");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_mis=%0d", n_mis);
        $fatal(1, "time limit");
    end

    task automatic set_idle();
        bus1.En       = 1'b0;
        bus1.Wreg     = 1'b0;
        bus1.M2reg    = 1'b0;
        bus1.Mem_data = '0;
        bus1.Alu_data = '0;
        bus1.Wn       = '0;
        bus1.Valid    = 1'b0;
        bus1.Rn1      = '0;
        bus1.Rn2      = '0;
    endtask

    // Advance one edge, tracking the expected retired count, and return at the falling edge.
    task automatic step();
        @(posedge Clk);
        if (!Clrn && bus1.En && bus1.Valid) ret_exp = ret_exp + 1;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        Clrn = 1'b1;
        set_idle();
        bus1.Rn1 = 5'd5;
        bus1.Rn2 = 5'd31;
        ret_exp  = '0;
        repeat (2) @(negedge Clk);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Retired, bus0.Retired} !== {e, e}) begin
            n_mis++;
            $display("FAIL reset_retired_during: got %h/%h want %h", bus1.Retired, bus0.Retired, e);
        end
        Clrn = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, bus1.Retired} !== {5{e}}) begin
            n_mis++;
            $display("FAIL reset_read: got Qa=%h Qb=%h Qa0=%h Qb0=%h Ret=%h want %h",
                     bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, bus1.Retired, e);
        end
        @(negedge Clk);
    endtask

    task automatic test_write_sources();
        logic [31:0] e;
        // ALU source
        bus1.En = 1'b1; bus1.Wreg = 1'b1; bus1.M2reg = 1'b0; bus1.Valid = 1'b1;
        bus1.Alu_data = 32'hDEAD_BEEF; bus1.Mem_data = 32'hA5A5_A5A5; bus1.Wn = 5'd7;
        #1;
        exp_q.push_back(32'hDEAD_BEEF);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Wdata, bus0.Wdata} !== {e, e}) begin
            n_mis++;
            $display("FAIL wdata_alu: got %h/%h want %h", bus1.Wdata, bus0.Wdata, e);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        bus1.Wreg = 1'b0; bus1.Valid = 1'b0; bus1.Rn1 = 5'd7;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus0.Qa} !== {e, e}) begin
            n_mis++;
            $display("FAIL write_alu: got %h/%h want %h", bus1.Qa, bus0.Qa, e);
        end
        exp_q.push_back(32'd1);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Retired, bus0.Retired} !== {e, e}) begin
            n_mis++;
            $display("FAIL retired_after_first: got %h/%h want %h", bus1.Retired, bus0.Retired, e);
        end
        // memory source
        bus1.Wreg = 1'b1; bus1.M2reg = 1'b1; bus1.Valid = 1'b1;
        bus1.Mem_data = 32'h1234_5678; bus1.Alu_data = 32'hCAFE_F00D;
        #1;
        exp_q.push_back(32'h1234_5678);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Wdata, bus0.Wdata} !== {e, e}) begin
            n_mis++;
            $display("FAIL wdata_mem: got %h/%h want %h", bus1.Wdata, bus0.Wdata, e);
        end
        exp_q.push_back(32'h1234_5678);
        step();
        bus1.Wreg = 1'b0; bus1.Valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus0.Qa, bus1.Retired} !== {e, e, 32'd2}) begin
            n_mis++;
            $display("FAIL write_mem: got %h/%h ret=%h want %h ret=2", bus1.Qa, bus0.Qa, bus1.Retired, e);
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] e;
        bus1.En = 1'b1; bus1.Wreg = 1'b1; bus1.M2reg = 1'b0; bus1.Valid = 1'b1;
        bus1.Alu_data = 32'hFFFF_FFFF; bus1.Wn = 5'd0; bus1.Rn1 = 5'd0; bus1.Rn2 = 5'd0;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb} !== {4{e}}) begin
            n_mis++;
            $display("FAIL zero_reg_during: got %h %h %h %h want %h", bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, e);
        end
        exp_q.push_back(32'h0);
        step();
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb} !== {4{e}}) begin
            n_mis++;
            $display("FAIL zero_reg_after: got %h %h %h %h want %h", bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, e);
        end
        bus1.Wreg = 1'b0; bus1.Valid = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        bus1.En = 1'b1; bus1.Wreg = 1'b1; bus1.M2reg = 1'b0; bus1.Valid = 1'b1;
        bus1.Alu_data = 32'h11; bus1.Wn = 5'd3;
        exp_q.push_back(32'h11);
        step();
        bus1.Wreg = 1'b0; bus1.Valid = 1'b0; bus1.Rn1 = 5'd3; bus1.Rn2 = 5'd3;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb} !== {4{e}}) begin
            n_mis++;
            $display("FAIL reg3_setup: got %h %h %h %h want %h", bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, e);
        end
        // stalled: bypass suppressed and no write lands
        bus1.En = 1'b0; bus1.Wreg = 1'b1; bus1.Valid = 1'b1; bus1.Alu_data = 32'h22;
        #1;
        exp_q.push_back(32'h11);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb} !== {4{e}}) begin
            n_mis++;
            $display("FAIL stall_no_bypass: got %h %h %h %h want %h", bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, e);
        end
        exp_q.push_back(32'h11);
        step();
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus0.Qa, bus1.Retired} !== {e, e, ret_exp}) begin
            n_mis++;
            $display("FAIL stall_no_write: got %h/%h ret=%h want %h ret=%h",
                     bus1.Qa, bus0.Qa, bus1.Retired, e, ret_exp);
        end
        // enabled: bypass instance sees new value before the edge, plain instance after
        bus1.En = 1'b1;
        #1;
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h11);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb} !== {e, e}) begin
            n_mis++;
            $display("FAIL bypass_on_before: got %h %h want %h", bus1.Qa, bus1.Qb, e);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus0.Qa, bus0.Qb} !== {e, e}) begin
            n_mis++;
            $display("FAIL bypass_off_before: got %h %h want %h", bus0.Qa, bus0.Qb, e);
        end
        exp_q.push_back(32'h22);
        step();
        bus1.Wreg = 1'b0; bus1.Valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb} !== {4{e}}) begin
            n_mis++;
            $display("FAIL bypass_after_edge: got %h %h %h %h want %h", bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, e);
        end
        // only port A matches the pending write
        bus1.Rn2 = 5'd7; bus1.Wreg = 1'b1; bus1.Valid = 1'b1; bus1.Alu_data = 32'h33;
        #1;
        exp_q.push_back(32'h33);
        exp_q.push_back(32'h1234_5678);
        e = exp_q.pop_front();
        n_cmp++;
        if (bus1.Qa !== e) begin
            n_mis++;
            $display("FAIL bypass_port_a_only: got %h want %h", bus1.Qa, e);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (bus1.Qb !== e) begin
            n_mis++;
            $display("FAIL bypass_port_b_untouched: got %h want %h", bus1.Qb, e);
        end
        step();
        bus1.Wreg = 1'b0; bus1.Valid = 1'b0;
    endtask

    task automatic test_counter();
        logic [31:0] e;
        logic [31:0] base;
        base = ret_exp;
        bus1.Wreg = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus1.En    = (c != 4) && (c != 5);
            bus1.Valid = (c != 8);
            step();
        end
        bus1.En = 1'b0; bus1.Valid = 1'b0;
        #1;
        exp_q.push_back(base + 32'd7);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Retired, bus0.Retired} !== {e, e}) begin
            n_mis++;
            $display("FAIL counter_stall: got %h/%h want %h", bus1.Retired, bus0.Retired, e);
        end
        // preload the counter to its top value, then retire one instruction
        u_byp.retired_q   = 32'hFFFF_FFFF;
        u_nobyp.retired_q = 32'hFFFF_FFFF;
        ret_exp = 32'hFFFF_FFFF;
        #1;
        bus1.En = 1'b1; bus1.Valid = 1'b1;
        exp_q.push_back(32'h0);
        step();
        bus1.En = 1'b0; bus1.Valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Retired, bus0.Retired} !== {e, e}) begin
            n_mis++;
            $display("FAIL counter_wrap: got %h/%h want %h", bus1.Retired, bus0.Retired, e);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        bus1.En = 1'b1; bus1.Wreg = 1'b1; bus1.M2reg = 1'b0; bus1.Valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            bus1.Wn       = 5'(r);
            bus1.Alu_data = 32'h100 + 32'(r);
            exp_q.push_back(32'h100 + 32'(r));
            step();
        end
        bus1.Wreg = 1'b0; bus1.Valid = 1'b0; bus1.En = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            bus1.Rn1 = 5'(r);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus1.Qa, bus0.Qa} !== {e, e}) begin
                n_mis++;
                $display("FAIL pre_reset_reg%0d: got %h/%h want %h", r, bus1.Qa, bus0.Qa, e);
            end
        end
        @(negedge Clk);
        bus1.Wn = 5'd9; bus1.Alu_data = 32'h99; bus1.Wreg = 1'b1; bus1.En = 1'b1; bus1.Valid = 1'b1;
        bus1.Rn1 = 5'd1; bus1.Rn2 = 5'd4;
        #3;
        Clrn = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, bus1.Retired} !== {5{e}}) begin
            n_mis++;
            $display("FAIL async_clear_immediate: got %h %h %h %h ret=%h want %h",
                     bus1.Qa, bus1.Qb, bus0.Qa, bus0.Qb, bus1.Retired, e);
        end
        @(posedge Clk);
        #1;
        Clrn = 1'b0;
        ret_exp = '0;
        bus1.Wreg = 1'b0; bus1.En = 1'b0; bus1.Valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus1.Rn1 = (k == 4) ? 5'd9 : 5'(k + 1);
            #1;
            exp_q.push_back(32'h0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus1.Qa, bus0.Qa} !== {e, e}) begin
                n_mis++;
                $display("FAIL post_reset_reg%0d: got %h/%h want %h", bus1.Rn1, bus1.Qa, bus0.Qa, e);
            end
        end
        n_cmp++;
        if ({bus1.Retired, bus0.Retired} !== {ret_exp, ret_exp}) begin
            n_mis++;
            $display("FAIL post_reset_retired: got %h/%h want %h", bus1.Retired, bus0.Retired, ret_exp);
        end
        @(negedge Clk);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        Clrn  = 1'b1;
        set_idle();
        test_reset();
        test_write_sources();
        test_zero_reg();
        test_bypass();
        test_counter();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
